input_port_array: RTL and testbench

Parametrised successor to the per-port input cluster: one leaf-side block that takes the single BFT stream into a leaf and demultiplexes valid packets by destination port into NUM_IN_PORTS independent FIFOs. It applies per-channel enable and source filtering, and presents each FIFO to user logic with valid/ack. Per-channel credit pulses return to the BFT interface. It sits between the leaf's BFT interface and the user operator, in a single clock domain.

---
 rtl/ipa_pkg.sv | 40 ++++
 rtl/ipa_fifo.sv | 51 +++++
 rtl/input_port_array.sv | 147 ++++++++++++++
 tb/tb_input_port_array.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ipa_pkg.sv
// Shared helpers for input_port_array: packet field geometry, clog2 and drop-reason codes.
package ipa_pkg;

    typedef enum logic [2:0] {
        DROP_NONE,
        DROP_RANGE,
        DROP_DISABLED,
        DROP_FILTER,
        DROP_FULL
    } drop_reason_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    function automatic int ctrl_bits(input int leaf_bits, input int port_bits);
        return leaf_bits + port_bits;
    endfunction

    function automatic int packet_bits(input int leaf_bits, input int port_bits, input int payload_bits);
        return 1 + 2 * ctrl_bits(leaf_bits, port_bits) + payload_bits;
    endfunction

    // {src_leaf, src_port} sits directly above the payload.
    function automatic int src_lsb(input int payload_bits);
        return payload_bits;
    endfunction

    function automatic int dst_port_lsb(input int leaf_bits, input int port_bits, input int payload_bits);
        return payload_bits + ctrl_bits(leaf_bits, port_bits);
    endfunction

    function automatic int valid_pos(input int leaf_bits, input int port_bits, input int payload_bits);
        return payload_bits + 2 * ctrl_bits(leaf_bits, port_bits);
    endfunction

endpackage

// File: rtl/ipa_fifo.sv
// Single-clock first-word-fall-through FIFO; head is visible the cycle after it is written.
module ipa_fifo #(
    parameter int DEPTH_BITS = 7,
    parameter int WIDTH      = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int DEPTH = 1 << DEPTH_BITS;

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_BITS-1:0] wr_ptr_q, rd_ptr_q;
    logic [DEPTH_BITS:0]   count_q;
    logic                  do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (DEPTH_BITS+1)'(DEPTH));
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    // NOTE: storage has no reset; only pointers and count do, so an empty FIFO never exposes stale data.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

    // NOTE: sequential state always uses non-blocking assignment so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/input_port_array.sv
// Leaf-side input cluster: registers the BFT stream, filters/decodes by destination port,
// pushes payloads into per-channel FIFOs and returns per-channel credit pulses.
module input_port_array
    import ipa_pkg::*;
#(
    parameter int NUM_LEAF_BITS         = 6,
    parameter int NUM_PORT_BITS         = 4,
    parameter int PAYLOAD_BITS          = 64,
    parameter int NUM_IN_PORTS          = 7,
    parameter int PORT_BASE             = 2,
    parameter int FIFO_DEPTH_BITS       = 7,
    parameter int FREESPACE_UPDATE_SIZE = 64,
    parameter int FILTER_EN             = 1,
    localparam int CTRL_BITS   = ctrl_bits(NUM_LEAF_BITS, NUM_PORT_BITS),
    localparam int PACKET_BITS = packet_bits(NUM_LEAF_BITS, NUM_PORT_BITS, PAYLOAD_BITS)
) (
    input  logic                               clk_bft,
    input  logic                               reset,
    input  logic [PACKET_BITS-1:0]             stream_in,
    input  logic [CTRL_BITS*NUM_IN_PORTS-1:0]  in_control_reg,
    input  logic [NUM_IN_PORTS-1:0]            chan_en,
    output logic [NUM_IN_PORTS-1:0]            freespace_update,
    output logic [PAYLOAD_BITS*NUM_IN_PORTS-1:0] dout2user,
    output logic [NUM_IN_PORTS-1:0]            vld2user,
    input  logic [NUM_IN_PORTS-1:0]            ack_user2b_in,
    output logic [NUM_IN_PORTS-1:0]            overflow,
    output logic [15:0]                        drop_count
);

    localparam int CH_BITS  = (NUM_IN_PORTS > 1) ? clog2(NUM_IN_PORTS) : 1;
    localparam int CNT_BITS = clog2(FREESPACE_UPDATE_SIZE + 1);
    localparam int VLD_POS  = valid_pos(NUM_LEAF_BITS, NUM_PORT_BITS, PAYLOAD_BITS);
    localparam int DST_LSB  = dst_port_lsb(NUM_LEAF_BITS, NUM_PORT_BITS, PAYLOAD_BITS);
    localparam int SRC_LSB  = src_lsb(PAYLOAD_BITS);

    logic                              s1_valid_q;
    logic [NUM_PORT_BITS-1:0]          s1_dst_port_q;
    logic [CTRL_BITS-1:0]              s1_src_q;
    logic [PAYLOAD_BITS-1:0]           s1_payload_q;
    logic [NUM_IN_PORTS-1:0]           s1_en_q;
    logic [CTRL_BITS*NUM_IN_PORTS-1:0] s1_ctrl_q;

    // Control inputs are captured with the packet so decode sees a consistent snapshot.
    always_ff @(posedge clk_bft or negedge reset) begin
        if (!reset) begin
            s1_valid_q    <= 1'b0;
            s1_dst_port_q <= '0;
            s1_src_q      <= '0;
            s1_payload_q  <= '0;
            s1_en_q       <= '0;
            s1_ctrl_q     <= '0;
        end else begin
            s1_valid_q    <= stream_in[VLD_POS];
            s1_dst_port_q <= stream_in[DST_LSB +: NUM_PORT_BITS];
            s1_src_q      <= stream_in[SRC_LSB +: CTRL_BITS];
            s1_payload_q  <= stream_in[PAYLOAD_BITS-1:0];
            s1_en_q       <= chan_en;
            s1_ctrl_q     <= in_control_reg;
        end
    end

    int                      dst_rel;
    logic [CH_BITS-1:0]      ch_idx;
    drop_reason_e            reason;
    logic [NUM_IN_PORTS-1:0] push_vec, pop_vec, fifo_empty, fifo_full;

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        dst_rel  = int'(s1_dst_port_q) - PORT_BASE;
        ch_idx   = '0;
        reason   = DROP_NONE;
        push_vec = '0;
        if (s1_valid_q) begin
            if (dst_rel < 0 || dst_rel >= NUM_IN_PORTS) begin
                reason = DROP_RANGE;
            end else begin
                ch_idx = CH_BITS'(dst_rel);
                if (!s1_en_q[ch_idx])
                    reason = DROP_DISABLED;
                else if (FILTER_EN != 0 && s1_src_q != s1_ctrl_q[ch_idx*CTRL_BITS +: CTRL_BITS])
                    reason = DROP_FILTER;
                else if (fifo_full[ch_idx])
                    reason = DROP_FULL;
                else
                    push_vec[ch_idx] = 1'b1;
            end
        end
    end

    logic [NUM_IN_PORTS-1:0] overflow_q;
    logic [15:0]             drop_count_q;

    always_ff @(posedge clk_bft or negedge reset) begin
        if (!reset) begin
            overflow_q   <= '0;
            drop_count_q <= '0;
        end else if (s1_valid_q && reason != DROP_NONE) begin
            if (drop_count_q != 16'hFFFF) drop_count_q <= drop_count_q + 16'd1;
            if (reason == DROP_FULL) overflow_q[ch_idx] <= 1'b1;
        end
    end

    logic [CNT_BITS-1:0]     pop_cnt_q [NUM_IN_PORTS];
    logic [NUM_IN_PORTS-1:0] freespace_q;

    always_ff @(posedge clk_bft or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_IN_PORTS; i++) pop_cnt_q[i] <= '0;
            freespace_q <= '0;
        end else begin
            freespace_q <= '0;
            for (int i = 0; i < NUM_IN_PORTS; i++) begin
                if (pop_vec[i]) begin
                    if (pop_cnt_q[i] == CNT_BITS'(FREESPACE_UPDATE_SIZE - 1)) begin
                        pop_cnt_q[i]   <= '0;
                        freespace_q[i] <= 1'b1;
                    end else begin
                        pop_cnt_q[i] <= pop_cnt_q[i] + 1'b1;
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_IN_PORTS; g++) begin : g_chan
        ipa_fifo #(
            .DEPTH_BITS(FIFO_DEPTH_BITS),
            .WIDTH     (PAYLOAD_BITS)
        ) u_fifo (
            .clk    (clk_bft),
            .rst_n  (reset),
            .push_i (push_vec[g]),
            .din_i  (s1_payload_q),
            .pop_i  (pop_vec[g]),
            .dout_o (dout2user[g*PAYLOAD_BITS +: PAYLOAD_BITS]),
            .empty_o(fifo_empty[g]),
            .full_o (fifo_full[g])
        );
    end

    assign vld2user         = ~fifo_empty;
    assign pop_vec          = vld2user & ack_user2b_in;
    assign overflow         = overflow_q;
    assign drop_count       = drop_count_q;
    assign freespace_update = freespace_q;

endmodule

// File: tb/tb_input_port_array.sv
// Randomised scoreboard bench for input_port_array (credit size reduced to 4 pops).
module tb_input_port_array;

    localparam int NCH   = 7;
    localparam int PB    = 2;
    localparam int FSU   = 4;
    localparam int DEPTH = 128;
    localparam int PKTW  = 85;

    localparam int ACK_OFF  = 0;
    localparam int ACK_ALL  = 1;
    localparam int ACK_RAND = 2;

    logic              clk_bft = 1'b0;
    logic              reset;
    logic [PKTW-1:0]   stream_in;
    logic [10*NCH-1:0] in_control_reg;
    logic [NCH-1:0]    chan_en;
    logic [NCH-1:0]    freespace_update;
    logic [64*NCH-1:0] dout2user;
    logic [NCH-1:0]    vld2user;
    logic [NCH-1:0]    ack;
    logic [NCH-1:0]    overflow;
    logic [15:0]       drop_count;

    input_port_array #(.FREESPACE_UPDATE_SIZE(FSU)) dut (
        .clk_bft         (clk_bft),
        .reset           (reset),
        .stream_in       (stream_in),
        .in_control_reg  (in_control_reg),
        .chan_en         (chan_en),
        .freespace_update(freespace_update),
        .dout2user       (dout2user),
        .vld2user        (vld2user),
        .ack_user2b_in   (ack),
        .overflow        (overflow),
        .drop_count      (drop_count)
    );

    always #5 clk_bft = ~clk_bft;

    int checks = 0;
    int errors = 0;

    logic [63:0]    exp_q [NCH][$];
    int             acc_total [NCH];
    int             pops [NCH];
    int             pulses [NCH];
    int             exp_drops;
    logic [NCH-1:0] exp_ovf;
    int             ack_mode = ACK_OFF;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < NCH; i++) begin
            exp_q[i].delete();
            acc_total[i] = 0;
            pops[i]      = 0;
            pulses[i]    = 0;
        end
        exp_drops = 0;
        exp_ovf   = '0;
    endtask

    // Reference decision made from the packet rules; caller sits at posedge+1.
    task automatic send(input int dst_port, input logic [9:0] src, input logic [63:0] payload);
        int ch;
        ch = dst_port - PB;
        stream_in = {1'b1, 6'($urandom), 4'(dst_port), src, payload};
        if (dst_port < PB || ch >= NCH)                   exp_drops++;
        else if (!chan_en[ch])                             exp_drops++;
        else if (src != in_control_reg[ch*10 +: 10])       exp_drops++;
        else if (exp_q[ch].size() >= DEPTH) begin
            exp_drops++;
            exp_ovf[ch] = 1'b1;
        end else begin
            exp_q[ch].push_back(payload);
            acc_total[ch]++;
        end
        @(posedge clk_bft); #1;
        stream_in = '0;
    endtask

    function automatic logic [9:0] src_of(input int ch);
        return in_control_reg[ch*10 +: 10];
    endfunction

    task automatic drain(input string name);
        bit done;
        done = 1'b0;
        ack_mode = ACK_ALL;
        for (int c = 0; c < 400 && !done; c++) begin
            @(posedge clk_bft); #1;
            done = 1'b1;
            for (int i = 0; i < NCH; i++) if (exp_q[i].size() != 0) done = 1'b0;
        end
        repeat (3) @(posedge clk_bft);
        #1;
        check({name, "_drained"}, 64'(done), 64'd1);
        check({name, "_vld_idle"}, 64'(vld2user), 64'd0);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk_bft);
        #1;
    endtask

    // Ack driver: settles after the main driver within each cycle.
    initial begin
        ack = '0;
        forever begin
            @(posedge clk_bft); #2;
            case (ack_mode)
                ACK_ALL:  ack = '1;
                ACK_RAND: ack = NCH'($urandom);
                default:  ack = '0;
            endcase
        end
    end

    // Monitor: pops the scoreboard whenever the user side accepts a head entry.
    initial begin
        forever begin
            @(negedge clk_bft);
            if (reset) begin
                for (int i = 0; i < NCH; i++) begin
                    if (freespace_update[i]) begin
                        pulses[i]++;
                        check($sformatf("fsu_align_ch%0d", i), 64'(pops[i] % FSU), 64'd0);
                    end
                    if (vld2user[i] && ack[i]) begin
                        check($sformatf("pop_expected_ch%0d", i), 64'(exp_q[i].size() != 0), 64'd1);
                        if (exp_q[i].size() != 0)
                            check($sformatf("dout_ch%0d", i), dout2user[i*64 +: 64], exp_q[i].pop_front());
                        pops[i]++;
                    end
                end
            end
        end
    end

    initial begin
        reset     = 1'b0;
        stream_in = '0;
        chan_en   = '1;
        for (int i = 0; i < NCH; i++) in_control_reg[i*10 +: 10] = 10'($urandom);
        clear_model();

        wait_cycles(3);
        check("rst_vld", 64'(vld2user), 64'd0);
        check("rst_fsu", 64'(freespace_update), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        check("rst_drop", 64'(drop_count), 64'd0);
        check("rst_dout", 64'(|dout2user), 64'd0);
        reset = 1'b1;
        wait_cycles(2);

        // Single packet latency
        send(3, src_of(1), 64'hA5);
        check("lat_e0_vld", 64'(vld2user), 64'd0);
        wait_cycles(1);
        check("lat_e1_vld", 64'(vld2user), 64'b0000010);
        check("lat_e1_dout", dout2user[64 +: 64], 64'hA5);
        drain("single");

        // Credit pulses: 8 pops on channel 0
        ack_mode = ACK_OFF;
        wait_cycles(2);
        for (int n = 0; n < 8; n++) send(2, src_of(0), 64'($urandom) << 32 | 64'(n));
        wait_cycles(2);
        drain("credit");
        check("credit_pulses_ch0", 64'(pulses[0]), 64'(acc_total[0] / FSU));
        check("credit_pulses_ch0_abs", 64'(pulses[0]), 64'd2);

        // Overflow on channel 2
        ack_mode = ACK_OFF;
        wait_cycles(2);
        for (int n = 0; n <= DEPTH; n++) send(4, src_of(2), {32'($urandom), 32'(n)});
        wait_cycles(3);
        check("ovf_flags", 64'(overflow), 64'(exp_ovf));
        check("ovf_flags_abs", 64'(overflow), 64'b0000100);
        check("ovf_drop_count", 64'(drop_count), 64'(exp_drops));
        check("ovf_vld", 64'(vld2user), 64'b0000100);
        drain("ovf");

        // Filter, out-of-range and disabled-channel drops
        send(5, src_of(3) ^ 10'h040, 64'h1111);
        send(15, src_of(0), 64'h2222);
        chan_en[0] = 1'b0;
        send(2, src_of(0), 64'h3333);
        chan_en[0] = 1'b1;
        wait_cycles(3);
        check("drops_count", 64'(drop_count), 64'(exp_drops));
        check("drops_count_abs", 64'(drop_count), 64'd4);
        check("drops_vld", 64'(vld2user), 64'd0);

        // Random interleave on channels 0/3/6 with random acks
        ack_mode = ACK_RAND;
        for (int n = 0; n < 240; n++) begin
            int ch;
            logic [9:0] src;
            ch  = 3 * int'($urandom_range(0, 2));
            src = ($urandom_range(0, 9) == 0) ? (src_of(ch) ^ 10'h001) : src_of(ch);
            send(ch + PB, src, {$urandom, $urandom});
            if ($urandom_range(0, 3) == 0) wait_cycles(1);
        end
        wait_cycles(2);
        drain("rand");
        for (int i = 0; i < NCH; i++)
            check($sformatf("rand_pulses_ch%0d", i), 64'(pulses[i]), 64'(acc_total[i] / FSU));
        check("rand_drop_count", 64'(drop_count), 64'(exp_drops));
        check("rand_ovf", 64'(overflow), 64'(exp_ovf));

        // Reset with queued entries and a packet in stage 1
        ack_mode = ACK_OFF;
        wait_cycles(2);
        for (int n = 0; n < 5; n++) send(3, src_of(1), 64'(n + 100));
        wait_cycles(2);
        check("pre_rst_vld", 64'(vld2user), 64'b0000010);
        stream_in = {1'b1, 6'd0, 4'd3, src_of(1), 64'hDEAD};
        @(posedge clk_bft); #1;
        reset     = 1'b0;
        stream_in = '0;
        clear_model();
        #1;
        check("midrst_vld", 64'(vld2user), 64'd0);
        check("midrst_dout", 64'(|dout2user), 64'd0);
        check("midrst_ovf", 64'(overflow), 64'd0);
        check("midrst_drop", 64'(drop_count), 64'd0);
        check("midrst_fsu", 64'(freespace_update), 64'd0);
        wait_cycles(3);
        reset = 1'b1;
        wait_cycles(5);
        check("postrst_vld", 64'(vld2user), 64'd0);
        check("postrst_dout", 64'(|dout2user), 64'd0);
        send(8, src_of(6), 64'hBEEF);
        wait_cycles(1);
        check("postrst_new_vld", 64'(vld2user), 64'b1000000);
        drain("postrst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
